// File: rtl/dac_tx_pkg.sv
// Shared types and constants for the DAC serial transmit path.
package dac_tx_pkg;

  localparam int DAC_W = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} dac_tx_state_t;

endpackage

// File: rtl/dac_spi_tx_sclk_phase_gen.sv
// Divides clk into sclk half-periods of CLK_DIV cycles; phase_tick_o marks the last cycle of a phase.
module sclk_phase_gen
  import dac_tx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  input  logic toggle_i,
  output logic phase_tick_o,
  output logic sclk_level_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Level only toggles when asked, so the same counter can time the HOLD phase with sclk parked low.
  always_comb begin
    phase_tick_o = run_i && (cnt_q == LAST_CNT);
    cnt_d        = cnt_q;
    level_d      = level_q;
    if (clear_i) begin
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (run_i) begin
      if (phase_tick_o) begin
        cnt_d = '0;
        if (toggle_i) level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign sclk_level_o = level_q;

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter feeding filter output samples MSB-first to the board DAC.
// Optional DAC_TX_OFFSET_BIN_EN: invert the captured MSB (two's complement -> offset binary).
module dac_spi_tx
  import dac_tx_pkg::*;
#(
  parameter int DATA_W  = DAC_W,
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(CS_IDLE + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(CS_IDLE - 1);

  dac_tx_state_t     state_q;
  logic [DATA_W-1:0] shift_q, load_d;
  logic [BW-1:0]     bit_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic              s_ready_q, cs_n_q, busy_q, frame_done_q;
  logic              accept, phase_tick, sclk_level;

  assign accept = s_valid && s_ready_q;

`ifdef DAC_TX_OFFSET_BIN_EN
  assign load_d = {~s_data[DATA_W-1], s_data[DATA_W-2:0]};
`else
  assign load_d = s_data;
`endif

  sclk_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (accept),
    .run_i       ((state_q == SHIFT) || (state_q == HOLD)),
    .toggle_i    (state_q == SHIFT),
    .phase_tick_o(phase_tick),
    .sclk_level_o(sclk_level)
  );

  // mosi is the shift register MSB, so it moves only when the register shifts at the end of a high phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      s_ready_q    <= 1'b1;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= SHIFT;
            shift_q   <= load_d;
            bit_cnt_q <= '0;
            s_ready_q <= 1'b0;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (phase_tick && sclk_level) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= HOLD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (phase_tick) begin
            state_q      <= GAP;
            shift_q      <= '0;
            cs_n_q       <= 1'b1;
            frame_done_q <= 1'b1;
            gap_cnt_q    <= '0;
          end
        end
        GAP: begin
          if (gap_cnt_q == LAST_GAP) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign sclk       = sclk_level;
  assign mosi       = shift_q[DATA_W-1];
  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default-timing instance plus a CLK_DIV=1/CS_IDLE=1 instance.
module tb_dac_spi_tx;

  typedef struct {
    logic [15:0] data;
    logic [15:0] expPlain;
    logic [15:0] expOffset;
  } vec_t;

  typedef struct {
    logic [15:0] word;
    int firstRise, lastRise, rises, csHigh, doneCyc, doneCount, readyCyc;
    bit busyOk, mosiGapZero;
  } obs_t;

`ifdef DAC_TX_OFFSET_BIN_EN
  localparam bit OFFSET_BIN = 1'b1;
`else
  localparam bit OFFSET_BIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [15:0] sData, fData;
  logic sValid, fValid;
  logic sReady, sclk, mosi, csN, busy, frameDone;
  logic fReady, fSclk, fMosi, fCsN, fBusy, fDone;
  bit useFast;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dac_spi_tx dut (
    .clk(clk), .rst(rst), .s_data(sData), .s_valid(sValid), .s_ready(sReady),
    .sclk(sclk), .mosi(mosi), .cs_n(csN), .busy(busy), .frame_done(frameDone)
  );

  dac_spi_tx #(.DATA_W(16), .CLK_DIV(1), .CS_IDLE(1)) dutFast (
    .clk(clk), .rst(rst), .s_data(fData), .s_valid(fValid), .s_ready(fReady),
    .sclk(fSclk), .mosi(fMosi), .cs_n(fCsN), .busy(fBusy), .frame_done(fDone)
  );

  wire monSclk  = useFast ? fSclk  : sclk;
  wire monMosi  = useFast ? fMosi  : mosi;
  wire monCsN   = useFast ? fCsN   : csN;
  wire monBusy  = useFast ? fBusy  : busy;
  wire monDone  = useFast ? fDone  : frameDone;
  wire monReady = useFast ? fReady : sReady;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic v, input logic [15:0] d);
    if (useFast) begin
      fValid = v;
      fData  = d;
    end else begin
      sValid = v;
      sData  = d;
    end
  endtask

  // Called at a negedge while the selected DUT is idle; the following posedge is the accept edge.
  task automatic applyStimulus(input logic [15:0] d);
    driveInputs(1'b1, d);
  endtask

  // Cycle c is the c-th cycle after the accept edge; returns at the negedge where s_ready rises.
  task automatic observeFrame(input bit dropValid, input bit changeData,
                              input logic [15:0] newData, output obs_t o);
    logic prevSclk;
    o.word = '0; o.firstRise = -1; o.lastRise = -1; o.rises = 0;
    o.csHigh = -1; o.doneCyc = -1; o.doneCount = 0; o.readyCyc = -1;
    o.busyOk = 1'b1; o.mosiGapZero = 1'b0;
    prevSclk = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1 && dropValid) driveInputs(1'b0, useFast ? fData : sData);
      if (c == 10 && changeData) driveInputs(1'b1, newData);
      if (monSclk && !prevSclk) begin
        o.word = {o.word[14:0], monMosi};
        if (o.rises == 0) o.firstRise = c;
        o.lastRise = c;
        o.rises++;
      end
      prevSclk = monSclk;
      if (monCsN && o.csHigh < 0) begin
        o.csHigh = c;
        o.mosiGapZero = (monMosi == 1'b0);
      end
      if (monDone) begin
        o.doneCount++;
        if (o.doneCyc < 0) o.doneCyc = c;
      end
      if (monReady) begin
        o.readyCyc = c;
        if (monBusy) o.busyOk = 1'b0;
        break;
      end else if (!monBusy) begin
        o.busyOk = 1'b0;
      end
    end
  endtask

  task automatic checkFrame(input string tag, input obs_t o, input logic [15:0] expWord,
                            input int firstRise, input int lastRise, input int csHigh,
                            input int readyCyc);
    checkOutput({tag, ".word"}, int'(o.word), int'(expWord));
    checkOutput({tag, ".rises"}, o.rises, 16);
    checkOutput({tag, ".firstRise"}, o.firstRise, firstRise);
    checkOutput({tag, ".lastRise"}, o.lastRise, lastRise);
    checkOutput({tag, ".csHigh"}, o.csHigh, csHigh);
    checkOutput({tag, ".doneCyc"}, o.doneCyc, csHigh);
    checkOutput({tag, ".doneCount"}, o.doneCount, 1);
    checkOutput({tag, ".readyCyc"}, o.readyCyc, readyCyc);
    checkOutput({tag, ".busy"}, int'(o.busyOk), 1);
    checkOutput({tag, ".mosiGap"}, int'(o.mosiGapZero), 1);
  endtask

  initial begin
    vec_t vecs[5];
    obs_t o, o2;
    bit idleOk;
    int doneSeen;

    vecs[0] = '{16'hA5C3, 16'hA5C3, 16'h25C3};
    vecs[1] = '{16'h0000, 16'h0000, 16'h8000};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};
    vecs[4] = '{16'h1234, 16'h1234, 16'h9234};

    rst = 1'b1; sValid = 1'b0; fValid = 1'b0; sData = '0; fData = '0; useFast = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.s_ready", int'(sReady), 1);
    checkOutput("reset.sclk", int'(sclk), 0);
    checkOutput("reset.mosi", int'(mosi), 0);
    checkOutput("reset.cs_n", int'(csN), 1);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.frame_done", int'(frameDone), 0);
    checkOutput("reset.fast_ready", int'(fReady), 1);
    rst = 1'b0;

    idleOk = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!csN || sclk || busy || !sReady || frameDone) idleOk = 1'b0;
    end
    checkOutput("idle20", int'(idleOk), 1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].data);
      observeFrame(1'b1, 1'b0, 16'h0000, o);
      checkFrame($sformatf("vec%0d", i), o, OFFSET_BIN ? vecs[i].expOffset : vecs[i].expPlain,
                 5, 125, 133, 135);
      repeat (2) @(negedge clk);
    end

    // Back-to-back: valid held high, data changed mid-frame must not disturb the first frame.
    applyStimulus(16'h0001);
    observeFrame(1'b0, 1'b1, 16'hFFFF, o);
    observeFrame(1'b1, 1'b0, 16'h0000, o2);
    checkFrame("b2b.first", o, OFFSET_BIN ? 16'h8001 : 16'h0001, 5, 125, 133, 135);
    checkFrame("b2b.second", o2, OFFSET_BIN ? 16'h7FFF : 16'hFFFF, 5, 125, 133, 135);
    repeat (2) @(negedge clk);

    // Mid-frame reset at cycle 40.
    applyStimulus(16'h1234);
    doneSeen = 0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) sValid = 1'b0;
      if (frameDone) doneSeen++;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst.cs_n", int'(csN), 1);
    checkOutput("midrst.sclk", int'(sclk), 0);
    checkOutput("midrst.mosi", int'(mosi), 0);
    checkOutput("midrst.s_ready", int'(sReady), 1);
    checkOutput("midrst.busy", int'(busy), 0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frameDone) doneSeen++;
    end
    checkOutput("midrst.no_done", doneSeen, 0);
    applyStimulus(16'h5A0F);
    observeFrame(1'b1, 1'b0, 16'h0000, o);
    checkFrame("postrst", o, OFFSET_BIN ? 16'hDA0F : 16'h5A0F, 5, 125, 133, 135);
    repeat (2) @(negedge clk);

    // Fastest divider: sclk toggles every cycle.
    useFast = 1'b1;
    applyStimulus(16'h8001);
    observeFrame(1'b1, 1'b0, 16'h0000, o);
    checkFrame("fast", o, OFFSET_BIN ? 16'h0001 : 16'h8001, 2, 32, 34, 35);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
